// File: rtl/uart_tx_block.sv
// UART transmitter: one-deep holding register feeding a start/data/stop
// shifter. Each serial bit is held for CLKS_PER_BIT clock cycles, data goes
// out LSB first, and the stop-bit level is chosen per frame.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | line high, waiting for the holding register to fill
// START | driving the start bit (0)
// DATA  | driving data bits LSB first, shifting right after each bit
// STOP  | driving the latched stop-bit level; may chain into START
module uart_tx_block #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_stop_bit,
    input  logic                 tx_load,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 serial_out
);

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]           r_state;
    logic [DIV_W-1:0]     r_div;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_stop_lat;
    logic [DATA_BITS-1:0] r_hold_data;
    logic                 r_hold_stop;
    logic                 r_hold_full;
    logic                 r_serial;
    logic                 r_busy;
    logic                 r_done;

    logic w_bit_end;
    logic w_start_frame;

    assign w_bit_end     = (r_div == DIV_LAST);
    // The holding register empties on the same edge the shifter picks it up,
    // either from IDLE or at the very end of a stop bit (back-to-back frame).
    assign w_start_frame = r_hold_full &&
                           ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

    assign tx_ready   = ~r_hold_full;
    assign tx_busy    = r_busy;
    assign tx_done    = r_done;
    assign serial_out = r_serial;

    // Holding register: capture on an accepted load, release on frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
            r_hold_stop <= 1'b1;
        end else if (tx_load && !r_hold_full) begin
            r_hold_full <= 1'b1;
            r_hold_data <= tx_data;
            r_hold_stop <= tx_stop_bit;
        end else if (w_start_frame) begin
            r_hold_full <= 1'b0;
        end
    end

    // Shifter FSM with per-bit divider and data-bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_stop_lat <= 1'b1;
            r_serial   <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_div     <= '0;
                    r_bit_cnt <= '0;
                    r_serial  <= 1'b1;
                    if (r_hold_full) begin
                        r_state    <= S_START;
                        r_serial   <= 1'b0;
                        r_shift    <= r_hold_data;
                        r_stop_lat <= r_hold_stop;
                        r_busy     <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_div    <= '0;
                        r_state  <= S_DATA;
                        r_serial <= r_shift[0];
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_div <= '0;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= S_STOP;
                            r_serial  <= r_stop_lat;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                            r_serial  <= r_shift[1];
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_div  <= '0;
                        r_done <= 1'b1;
                        if (r_hold_full) begin
                            r_state    <= S_START;
                            r_serial   <= 1'b0;
                            r_shift    <= r_hold_data;
                            r_stop_lat <= r_hold_stop;
                        end else begin
                            r_state  <= S_IDLE;
                            r_serial <= 1'b1;
                            r_busy   <= 1'b0;
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_div    <= '0;
                    r_serial <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_block.sv
// Bench for uart_tx_block: frame-level reference model compared every cycle,
// a bench-side serial receiver, and directed literal expectations.
module tb_uart_tx_block;

    localparam int C     = 10;
    localparam int DB    = 8;
    localparam int FRAME = (DB + 2) * C;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_stop_bit = 1'b1;
    logic       tx_load = 1'b0;
    logic       tx_ready, tx_busy, tx_done, serial_out;

    always #5 clk = ~clk;

    uart_tx_block #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_stop_bit (tx_stop_bit),
        .tx_load     (tx_load),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .serial_out  (serial_out)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: a frame is a 10-bit vector {stop, data, start}
    // played out C cycles per bit; a queued byte starts the cycle after the
    // previous frame's last cycle.
    logic       m_valid = 1'b0;
    logic       m_hold_full = 1'b0;
    logic [7:0] m_hold_data = 8'h00;
    logic       m_hold_stop = 1'b1;
    logic       m_active = 1'b0;
    int         m_cyc = 0;
    logic [9:0] m_frame = 10'h3ff;
    logic       m_done = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid     <= 1'b1;
            m_hold_full <= 1'b0;
            m_active    <= 1'b0;
            m_cyc       <= 0;
            m_done      <= 1'b0;
        end else begin
            m_done <= m_active && (m_cyc == FRAME - 1);
            if (m_active && m_cyc < FRAME - 1) begin
                m_cyc <= m_cyc + 1;
            end else if (m_hold_full) begin
                m_active <= 1'b1;
                m_cyc    <= 0;
                m_frame  <= {m_hold_stop, m_hold_data, 1'b0};
            end else begin
                m_active <= 1'b0;
            end
            if (tx_load && !m_hold_full) begin
                m_hold_full <= 1'b1;
                m_hold_data <= tx_data;
                m_hold_stop <= tx_stop_bit;
            end else if (m_hold_full && (!m_active || m_cyc == FRAME - 1)) begin
                m_hold_full <= 1'b0;
            end
        end
    end

    // Every-cycle comparison against the reference model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("serial_out", {31'd0, serial_out}, {31'd0, (m_active ? m_frame[m_cyc / C] : 1'b1)});
                chk("tx_ready", {31'd0, tx_ready}, {31'd0, ~m_hold_full});
                chk("tx_busy", {31'd0, tx_busy}, {31'd0, m_active});
                chk("tx_done", {31'd0, tx_done}, {31'd0, m_done});
            end
        end
    end

    // Bench-side receiver: mid-bit sampling, records bytes, stop bits,
    // start-edge and tx_done cycle stamps.
    int         cyc = 0;
    logic [7:0] rx_q[$];
    logic       rx_stop_q[$];
    int         rx_start_q[$];
    int         done_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        int         mon_cnt;
        int         mon_start;
        int         k;
        logic [7:0] mon_byte;
        mon_cnt   = -1;
        mon_start = 0;
        mon_byte  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_cnt = -1;
            end else if (mon_cnt < 0) begin
                if (serial_out === 1'b0) begin
                    mon_cnt   = 0;
                    mon_start = cyc;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt % C == C / 2) begin
                    k = mon_cnt / C;
                    if (k == 0) begin
                        if (serial_out !== 1'b0) mon_cnt = -1;
                    end else if (k <= DB) begin
                        mon_byte[k-1] = serial_out;
                    end else begin
                        rx_q.push_back(mon_byte);
                        rx_stop_q.push_back(serial_out);
                        rx_start_q.push_back(mon_start);
                        mon_cnt = -1;
                    end
                end
            end
            if (tx_done === 1'b1) done_q.push_back(cyc);
        end
    end

    task automatic load_byte(input logic [7:0] d, input logic s);
        @(negedge clk);
        tx_data     = d;
        tx_stop_bit = s;
        tx_load     = 1'b1;
        @(negedge clk);
        tx_load     = 1'b0;
    endtask

    task automatic wait_ready(input int limit);
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready_timeout", {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (!(tx_busy === 1'b0 && tx_ready === 1'b1 && tx_done === 1'b0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", {31'd0, (n < limit)}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_lv;
        int         cur;
        int         zeros;

        // Reset with tx_load held high: nothing may be captured.
        rst     = 1'b1;
        tx_load = 1'b1;
        tx_data = 8'h77;
        repeat (2) @(negedge clk);
        chk("rst_serial", {31'd0, serial_out}, 32'd1);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        rst     = 1'b0;
        tx_load = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("post_rst_busy", {31'd0, tx_busy}, 32'd0);

        // Single frame 0xD5: start 0, data 1,0,1,0,1,0,1,1, stop 1.
        load_byte(8'hD5, 1'b1);
        chk("d5_capture_serial", {31'd0, serial_out}, 32'd1);
        chk("d5_capture_ready", {31'd0, tx_ready}, 32'd0);
        @(negedge clk);
        chk("d5_start_serial", {31'd0, serial_out}, 32'd0);
        chk("d5_start_ready", {31'd0, tx_ready}, 32'd1);
        chk("d5_start_busy", {31'd0, tx_busy}, 32'd1);
        exp_lv = 10'b11_1010_1010;
        cur = 0;
        for (int b = 0; b < 10; b++) begin
            while (cur < b * C + C / 2) begin
                @(negedge clk);
                cur++;
            end
            chk($sformatf("d5_level_%0d", b), {31'd0, serial_out}, {31'd0, exp_lv[b]});
        end
        while (tx_done !== 1'b1 && cur < 130) begin
            @(negedge clk);
            cur++;
        end
        chk("d5_done_cycle", cur, 32'd100);
        chk("d5_done_serial", {31'd0, serial_out}, 32'd1);
        chk("d5_done_busy", {31'd0, tx_busy}, 32'd0);
        @(negedge clk);
        chk("d5_done_one_cycle", {31'd0, tx_done}, 32'd0);
        wait_idle(50);
        chk("d5_rx_count", rx_q.size(), 32'd1);
        if (rx_q.size() >= 1) begin
            chk("d5_rx_byte", {24'd0, rx_q[0]}, 32'hD5);
            chk("d5_rx_stop", {31'd0, rx_stop_q[0]}, 32'd1);
        end

        // Back-to-back 0xA5 then 0x3C, with an ignored 0xFF overload.
        load_byte(8'hA5, 1'b1);
        wait_ready(20);
        load_byte(8'h3C, 1'b1);
        chk("b2b_hold_full", {31'd0, tx_ready}, 32'd0);
        load_byte(8'hFF, 1'b1);
        @(negedge clk);
        wait_idle(3 * FRAME);
        chk("b2b_rx_count", rx_q.size(), 32'd3);
        chk("b2b_done_count", done_q.size(), 32'd3);
        if (rx_q.size() >= 3) begin
            chk("b2b_rx_byte1", {24'd0, rx_q[1]}, 32'hA5);
            chk("b2b_rx_byte2", {24'd0, rx_q[2]}, 32'h3C);
            chk("b2b_start_gap", rx_start_q[2] - rx_start_q[1], FRAME);
        end
        if (done_q.size() >= 3) chk("b2b_done_gap", done_q[2] - done_q[1], FRAME);

        // Framing error (stop=0) and normal frame of 0x5A.
        load_byte(8'h5A, 1'b0);
        wait_idle(2 * FRAME);
        load_byte(8'h5A, 1'b1);
        wait_idle(2 * FRAME);
        chk("fe_rx_count", rx_q.size(), 32'd5);
        if (rx_q.size() >= 5) begin
            chk("fe_rx_byte", {24'd0, rx_q[3]}, 32'h5A);
            chk("fe_framing_error", {31'd0, (rx_stop_q[3] == 1'b0)}, 32'd1);
            chk("ok_rx_byte", {24'd0, rx_q[4]}, 32'h5A);
            chk("ok_data_ready", {31'd0, rx_stop_q[4]}, 32'd1);
        end

        // Reset in cycle 45 of a 0xD5 frame with 0x3C queued.
        load_byte(8'hD5, 1'b1);
        @(negedge clk);
        cur = 0;
        load_byte(8'h3C, 1'b1);
        cur += 2;
        while (cur < 45) begin
            @(negedge clk);
            cur++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_serial", {31'd0, serial_out}, 32'd1);
        chk("midrst_ready", {31'd0, tx_ready}, 32'd1);
        chk("midrst_busy", {31'd0, tx_busy}, 32'd0);
        chk("midrst_done", {31'd0, tx_done}, 32'd0);
        zeros = 0;
        repeat (250) begin
            @(negedge clk);
            if (serial_out !== 1'b1) zeros++;
        end
        chk("midrst_line_idle", zeros, 32'd0);
        chk("midrst_rx_count", rx_q.size(), 32'd5);
        chk("midrst_done_count", done_q.size(), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
